pipeline_ctrl: RTL and testbench

- Front-end hazard and stall scheduler for the 5-stage MIPS pipeline.
- Each cycle it decides whether the PC and the IF/ID register advance, hold, or are flushed, and whether ID/EX receives a bubble or the execute stage holds.
- It arbitrates between four sources: load-use hazards, a busy multi-cycle mul/div unit, taken branches/jumps, and instruction-memory wait.
- It also keeps saturating stall and flush counters for performance analysis.

---
 rtl/pipeline_ctrl.sv | 157 +++++++++++++++
 tb/tb_pipeline_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Front-end hazard/stall scheduler for the 5-stage MIPS pipeline.
// Arbitrates mul/div busy, load-use, redirect and I-mem wait; counts stall/flush cycles.
module pipeline_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             id_redirect,
  input  logic             md_busy,
  input  logic             im_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_hold,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, LU_STALL, MD_WAIT, IM_WAIT} state_t;

  localparam logic [3:0]       LU_INIT = 4'(LOAD_STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t     state, state_nxt;
  logic [3:0] lu_cnt, lu_cnt_nxt;
  logic       redirect_pending, redirect_pending_nxt;
  logic       hazard;
  logic       run_eval;

  assign hazard = ex_mem_read && (ex_rt != 5'd0) && id_valid &&
                  ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  always_comb begin
    // NOTE: every output and next-state value gets a default here so no path infers a latch.
    state_nxt            = state;
    lu_cnt_nxt           = lu_cnt;
    redirect_pending_nxt = redirect_pending;
    pc_write             = 1'b1;
    if_id_write          = 1'b1;
    if_id_flush          = 1'b0;
    id_ex_flush          = 1'b0;
    ex_hold              = 1'b0;
    run_eval             = 1'b0;

    case (state)
      RUN, MD_WAIT: run_eval = 1'b1;
      LU_STALL: begin
        if (md_busy) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          ex_hold     = 1'b1;
          lu_cnt_nxt  = 4'd0;
          state_nxt   = MD_WAIT;
        end else begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
          lu_cnt_nxt  = lu_cnt - 4'd1;
          if (lu_cnt == 4'd1) state_nxt = RUN;
        end
      end
      IM_WAIT: begin
        // Fetch stays outstanding through a mul/div freeze, so the state is kept.
        if (md_busy) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          ex_hold     = 1'b1;
        end else if (id_redirect) begin
          if_id_write          = 1'b0;
          if_id_flush          = 1'b1;
          redirect_pending_nxt = 1'b1;
        end else if (!im_ready) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          if_id_flush = 1'b1;
        end else if (redirect_pending) begin
          // Returned word belongs to the pre-redirect fetch: drop it and wait again.
          pc_write             = 1'b0;
          if_id_write          = 1'b0;
          if_id_flush          = 1'b1;
          redirect_pending_nxt = 1'b0;
        end else begin
          run_eval = 1'b1;
        end
      end
      default: state_nxt = RUN;
    endcase

    if (run_eval) begin
      if (md_busy) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        ex_hold     = 1'b1;
        state_nxt   = MD_WAIT;
      end else if (hazard) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
        if (LOAD_STALL_CYCLES > 1) begin
          state_nxt  = LU_STALL;
          lu_cnt_nxt = LU_INIT;
        end else begin
          state_nxt  = RUN;
        end
      end else if (id_redirect) begin
        if_id_flush = 1'b1;
        if (!im_ready) begin
          redirect_pending_nxt = 1'b1;
          state_nxt            = IM_WAIT;
        end else begin
          state_nxt = RUN;
        end
      end else if (!im_ready) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        if_id_flush = 1'b1;
        state_nxt   = IM_WAIT;
      end else begin
        state_nxt = RUN;
      end
    end

    if (rst) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      ex_hold     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= RUN;
      lu_cnt           <= 4'd0;
      redirect_pending <= 1'b0;
      stall_cnt        <= '0;
      flush_cnt        <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state            <= state_nxt;
      lu_cnt           <= lu_cnt_nxt;
      redirect_pending <= redirect_pending_nxt;
      if (!pc_write && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (if_id_flush && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized self-checking bench for pipeline_ctrl: three instances (1/3/4 load bubbles,
// one with 4-bit counters) compared every cycle against a stall-budget reference model.
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs = '0;
  logic [4:0] id_rt = '0;
  logic       id_uses_rt = 1'b0;
  logic       ex_mem_read = 1'b0;
  logic [4:0] ex_rt = '0;
  logic       id_redirect = 1'b0;
  logic       md_busy = 1'b0;
  logic       im_ready = 1'b1;

  logic [2:0]  pc_w, ifid_w, ifid_f, idex_f, hold;
  logic [31:0] sc0, sc1, fc0, fc1;
  logic [3:0]  sc2, fc2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(32)) u0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .id_redirect(id_redirect), .md_busy(md_busy), .im_ready(im_ready),
    .pc_write(pc_w[0]), .if_id_write(ifid_w[0]), .if_id_flush(ifid_f[0]),
    .id_ex_flush(idex_f[0]), .ex_hold(hold[0]), .stall_cnt(sc0), .flush_cnt(fc0));

  pipeline_ctrl #(.LOAD_STALL_CYCLES(3), .CNT_W(32)) u1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .id_redirect(id_redirect), .md_busy(md_busy), .im_ready(im_ready),
    .pc_write(pc_w[1]), .if_id_write(ifid_w[1]), .if_id_flush(ifid_f[1]),
    .id_ex_flush(idex_f[1]), .ex_hold(hold[1]), .stall_cnt(sc1), .flush_cnt(fc1));

  pipeline_ctrl #(.LOAD_STALL_CYCLES(4), .CNT_W(4)) u2 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .id_redirect(id_redirect), .md_busy(md_busy), .im_ready(im_ready),
    .pc_write(pc_w[2]), .if_id_write(ifid_w[2]), .if_id_flush(ifid_f[2]),
    .id_ex_flush(idex_f[2]), .ex_hold(hold[2]), .stall_cnt(sc2), .flush_cnt(fc2));

  // Reference model: remaining load bubbles, outstanding fetch, stale-word flag, counts.
  int     lsc_of[3] = '{1, 3, 4};
  longint max_of[3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd15};
  int     m_lu[3], n_lu[3];
  bit     m_fw[3], n_fw[3], m_stale[3], n_stale[3];
  longint m_sc[3], m_fc[3];
  bit     e_pc[3], e_w[3], e_iff[3], e_ief[3], e_hold[3];

  function automatic logic [31:0] get_sc(int k);
    case (k)
      0: return sc0;
      1: return sc1;
      default: return {28'd0, sc2};
    endcase
  endfunction

  function automatic logic [31:0] get_fc(int k);
    case (k)
      0: return fc0;
      1: return fc1;
      default: return {28'd0, fc2};
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_eval(input int k);
    bit hz, run;
    hz = ex_mem_read && ex_rt != 0 && id_valid &&
         (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
    e_pc[k] = 1; e_w[k] = 1; e_iff[k] = 0; e_ief[k] = 0; e_hold[k] = 0;
    n_lu[k] = m_lu[k]; n_fw[k] = m_fw[k]; n_stale[k] = m_stale[k];
    run = 0;
    if (md_busy) begin
      e_pc[k] = 0; e_w[k] = 0; e_hold[k] = 1; n_lu[k] = 0;
    end else if (m_lu[k] > 0) begin
      e_pc[k] = 0; e_w[k] = 0; e_ief[k] = 1; n_lu[k] = m_lu[k] - 1;
    end else if (m_fw[k]) begin
      if (id_redirect) begin
        e_w[k] = 0; e_iff[k] = 1; n_stale[k] = 1;
      end else if (!im_ready) begin
        e_pc[k] = 0; e_w[k] = 0; e_iff[k] = 1;
      end else if (m_stale[k]) begin
        e_pc[k] = 0; e_w[k] = 0; e_iff[k] = 1; n_stale[k] = 0;
      end else begin
        n_fw[k] = 0; run = 1;
      end
    end else begin
      run = 1;
    end
    if (run) begin
      if (hz) begin
        e_pc[k] = 0; e_w[k] = 0; e_ief[k] = 1; n_lu[k] = lsc_of[k] - 1;
      end else if (id_redirect) begin
        e_iff[k] = 1;
        if (!im_ready) begin n_fw[k] = 1; n_stale[k] = 1; end
      end else if (!im_ready) begin
        e_pc[k] = 0; e_w[k] = 0; e_iff[k] = 1; n_fw[k] = 1;
      end
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_lu[k] = 0; m_fw[k] = 0; m_stale[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
    end
  endtask

  // Entered just after a posedge; leaves just after the next posedge.
  task automatic step();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      model_eval(k);
      check($sformatf("u%0d pc_write", k), 32'(pc_w[k]), 32'(e_pc[k]));
      check($sformatf("u%0d if_id_write", k), 32'(ifid_w[k]), 32'(e_w[k]));
      check($sformatf("u%0d if_id_flush", k), 32'(ifid_f[k]), 32'(e_iff[k]));
      check($sformatf("u%0d id_ex_flush", k), 32'(idex_f[k]), 32'(e_ief[k]));
      check($sformatf("u%0d ex_hold", k), 32'(hold[k]), 32'(e_hold[k]));
      check($sformatf("u%0d flush_hold_excl", k), 32'(hold[k] & idex_f[k]), 32'd0);
      check($sformatf("u%0d stall_cnt", k), get_sc(k), 32'(m_sc[k]));
      check($sformatf("u%0d flush_cnt", k), get_fc(k), 32'(m_fc[k]));
    end
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      m_lu[k] = n_lu[k]; m_fw[k] = n_fw[k]; m_stale[k] = n_stale[k];
      if (!e_pc[k] && m_sc[k] < max_of[k]) m_sc[k]++;
      if (e_iff[k] && m_fc[k] < max_of[k]) m_fc[k]++;
    end
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_mem_read = 0; ex_rt = 0;
    id_redirect = 0; md_busy = 0; im_ready = 1;
  endtask

  task automatic load_use(input logic [4:0] r);
    ex_mem_read = 1; ex_rt = r; id_rs = r; id_valid = 1;
  endtask

  task automatic do_reset();
    rst = 1;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("u%0d rst pc_write", k), 32'(pc_w[k]), 32'd0);
      check($sformatf("u%0d rst if_id_write", k), 32'(ifid_w[k]), 32'd0);
      check($sformatf("u%0d rst if_id_flush", k), 32'(ifid_f[k]), 32'd1);
      check($sformatf("u%0d rst id_ex_flush", k), 32'(idex_f[k]), 32'd1);
      check($sformatf("u%0d rst ex_hold", k), 32'(hold[k]), 32'd0);
      check($sformatf("u%0d rst stall_cnt", k), get_sc(k), 32'd0);
      check($sformatf("u%0d rst flush_cnt", k), get_fc(k), 32'd0);
    end
    model_reset();
    @(posedge clk);
    #2 rst = 0;
  endtask

  initial begin
    idle();
    do_reset();

    // Free flow after reset.
    repeat (4) step();
    check("flow stall_cnt", sc0, 32'd0);
    check("flow flush_cnt", fc0, 32'd0);

    // Single load-use hazard across the three bubble settings.
    do_reset();
    load_use(5'd5); step();
    idle(); repeat (5) step();
    check("lu1 stall_cnt", sc0, 32'd1);
    check("lu3 stall_cnt", sc1, 32'd3);
    check("lu4 stall_cnt", {28'd0, sc2}, 32'd4);

    // Load into r0 never stalls.
    do_reset();
    load_use(5'd0); step();
    idle(); step();
    check("r0 stall_cnt", sc0, 32'd0);

    // mul/div freeze overrides a concurrent hazard, which then shows once md_busy drops.
    do_reset();
    load_use(5'd7); md_busy = 1;
    repeat (6) step();
    check("md stall_cnt", sc0, 32'd6);
    md_busy = 0; step();
    check("md+lu stall_cnt", sc0, 32'd7);
    idle(); repeat (4) step();

    // Instruction-memory wait.
    do_reset();
    im_ready = 0; repeat (3) step();
    check("im flush_cnt", fc0, 32'd3);
    check("im stall_cnt", sc0, 32'd3);
    idle(); step();
    check("im resume flush_cnt", fc0, 32'd3);

    // Redirect during a miss: stale word dropped, then a second wait.
    do_reset();
    id_redirect = 1; im_ready = 0; step();
    id_redirect = 0; step();
    im_ready = 1; step();
    step();
    idle(); repeat (2) step();
    check("redir flush_cnt", fc0, 32'd3);
    check("redir stall_cnt", sc0, 32'd2);

    // Asynchronous reset in the middle of a long load-use stall.
    do_reset();
    load_use(5'd9); step();
    idle(); step();
    #2 do_reset();
    repeat (2) step();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        #2 do_reset();
      end
      id_valid    = ($urandom_range(0, 3) != 0);
      id_rs       = 5'($urandom_range(0, 3));
      id_rt       = 5'($urandom_range(0, 3));
      id_uses_rt  = 1'($urandom_range(0, 1));
      ex_mem_read = ($urandom_range(0, 9) < 3);
      ex_rt       = 5'($urandom_range(0, 3));
      id_redirect = ($urandom_range(0, 9) < 2);
      md_busy     = ($urandom_range(0, 19) < 3);
      im_ready    = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
